lcu_top: RTL and testbench



---
 rtl/lcu_top.sv | 126 ++++++++++++
 tb/tb_lcu_top.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lcu_top.sv
// lcu_top: dual 32-bit counter/threshold comparator block.
//
// The up pair (counter, threshold) and the down pair (counter_down,
// threshold_down) are registered. Every flag is decoded combinationally from
// those registers, so each flag is valid in the same cycle as the clock edge
// that updates the registers.
//
// Build option:
//   LCU_DOWN_PATH_EN  When defined, the down pair and the *_n flags are built.
//                     When undefined, the down pair is not built and every
//                     *_n flag is tied to 0. The ports are present either way.
//
// Ports:
//   count      in   clock; registers update on its rising edge
//   rst_n      in   asynchronous active-low reset; clears all registers
//   count_sw   in   1 = counter increments and counter_down decrements
//   thresh_sw  in   1 = reload the thresholds from the pre-edge counters
//                   0 = thresholds free-run
//   zero, max  out  counter == 0, counter == 0xFFFFFFFF
//   gtu..leu   out  unsigned compares of counter against threshold
//   gts..les   out  signed compares of counter against threshold
//   *_n        out  the same flags for counter_down against threshold_down
module lcu_top (
    input  logic count,
    input  logic rst_n,
    input  logic count_sw,
    input  logic thresh_sw,
    output logic zero,
    output logic max,
    output logic gtu,
    output logic ltu,
    output logic geu,
    output logic leu,
    output logic gts,
    output logic lts,
    output logic ges,
    output logic les,
    output logic zero_n,
    output logic max_n,
    output logic gtu_n,
    output logic ltu_n,
    output logic geu_n,
    output logic leu_n,
    output logic gts_n,
    output logic lts_n,
    output logic ges_n,
    output logic les_n
);

    logic [31:0] counter;
    logic [31:0] threshold;

    // Threshold reload uses the counter value from before this edge.
    always_ff @(posedge count or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            threshold <= '0;
        end else begin
            if (count_sw)
                counter <= counter + 32'd1;
            if (thresh_sw)
                threshold <= counter - 32'd31;
            else
                threshold <= threshold + 32'd1;
        end
    end

    // ge/le are the complements of lt/gt, so exactly one of gt, lt and
    // equal holds at all times.
    always_comb begin
        zero = (counter == 32'd0);
        max  = (counter == 32'hFFFF_FFFF);
        gtu  = (counter > threshold);
        ltu  = (counter < threshold);
        geu  = !ltu;
        leu  = !gtu;
        gts  = ($signed(counter) > $signed(threshold));
        lts  = ($signed(counter) < $signed(threshold));
        ges  = !lts;
        les  = !gts;
    end

`ifdef LCU_DOWN_PATH_EN
    logic [31:0] counter_down;
    logic [31:0] threshold_down;

    always_ff @(posedge count or negedge rst_n) begin
        if (!rst_n) begin
            counter_down   <= '0;
            threshold_down <= '0;
        end else begin
            if (count_sw)
                counter_down <= counter_down - 32'd1;
            if (thresh_sw)
                threshold_down <= counter_down + 32'd31;
            else
                threshold_down <= threshold_down - 32'd1;
        end
    end

    always_comb begin
        zero_n = (counter_down == 32'd0);
        max_n  = (counter_down == 32'hFFFF_FFFF);
        gtu_n  = (counter_down > threshold_down);
        ltu_n  = (counter_down < threshold_down);
        geu_n  = !ltu_n;
        leu_n  = !gtu_n;
        gts_n  = ($signed(counter_down) > $signed(threshold_down));
        lts_n  = ($signed(counter_down) < $signed(threshold_down));
        ges_n  = !lts_n;
        les_n  = !gts_n;
    end
`else
    assign zero_n = 1'b0;
    assign max_n  = 1'b0;
    assign gtu_n  = 1'b0;
    assign ltu_n  = 1'b0;
    assign geu_n  = 1'b0;
    assign leu_n  = 1'b0;
    assign gts_n  = 1'b0;
    assign lts_n  = 1'b0;
    assign ges_n  = 1'b0;
    assign les_n  = 1'b0;
`endif

endmodule

// File: tb/tb_lcu_top.sv
module tb_lcu_top;

    logic count;
    logic rst_n;
    logic count_sw;
    logic thresh_sw;
    logic zero, max, gtu, ltu, geu, leu, gts, lts, ges, les;
    logic zero_n, max_n, gtu_n, ltu_n, geu_n, leu_n, gts_n, lts_n, ges_n, les_n;

    int checks = 0;
    int errors = 0;

    lcu_top dut (
        .count    (count),
        .rst_n    (rst_n),
        .count_sw (count_sw),
        .thresh_sw(thresh_sw),
        .zero     (zero),
        .max      (max),
        .gtu      (gtu),
        .ltu      (ltu),
        .geu      (geu),
        .leu      (leu),
        .gts      (gts),
        .lts      (lts),
        .ges      (ges),
        .les      (les),
        .zero_n   (zero_n),
        .max_n    (max_n),
        .gtu_n    (gtu_n),
        .ltu_n    (ltu_n),
        .geu_n    (geu_n),
        .leu_n    (leu_n),
        .gts_n    (gts_n),
        .lts_n    (lts_n),
        .ges_n    (ges_n),
        .les_n    (les_n)
    );

    initial count = 1'b0;
    always #5 count = ~count;

    // Flag order: {zero,max,gtu,ltu,geu,leu,gts,lts,ges,les}
    localparam logic [9:0] RST_UP = 10'b10_0011_0011;
`ifdef LCU_DOWN_PATH_EN
    localparam logic [9:0] RST_DN = 10'b10_0011_0011;
`else
    localparam logic [9:0] RST_DN = 10'b0;
`endif

    typedef struct {
        logic        cs;
        logic        ts;
        logic [31:0] c;
        logic [31:0] t;
        logic [31:0] cd;
        logic [31:0] td;
    } vec_t;

    vec_t vecs[6];

    // Reference flags: compares done through a 33-bit borrow, signed via
    // MSB flip, independent of the relational operators.
    function automatic logic [9:0] flags(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] du;
        logic [32:0] ds;
        logic        eq;
        logic        lt_u;
        logic        lt_s;
        logic        gt_u;
        logic        gt_s;
        du   = {1'b0, a} - {1'b0, b};
        ds   = {1'b0, ~a[31], a[30:0]} - {1'b0, ~b[31], b[30:0]};
        eq   = ~|(a ^ b);
        lt_u = du[32];
        lt_s = ds[32];
        gt_u = !lt_u && !eq;
        gt_s = !lt_s && !eq;
        return {~|a, &a, gt_u, lt_u, !lt_u, !gt_u, gt_s, lt_s, !lt_s, !gt_s};
    endfunction

    function automatic logic [19:0] exp_all(input logic [31:0] c, input logic [31:0] t,
                                            input logic [31:0] cd, input logic [31:0] td);
        logic [9:0] dn;
`ifdef LCU_DOWN_PATH_EN
        dn = flags(cd, td);
`else
        dn = 10'b0 & {cd[9:0] ^ td[9:0]};
`endif
        return {flags(c, t), dn};
    endfunction

    function automatic logic [19:0] act_all();
        return {zero, max, gtu, ltu, geu, leu, gts, lts, ges, les,
                zero_n, max_n, gtu_n, ltu_n, geu_n, leu_n, gts_n, lts_n, ges_n, les_n};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] c_m, t_m, cd_m, td_m;

        vecs[0] = '{1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFE1, 32'hFFFF_FFFF, 32'h0000_001F};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFE2, 32'hFFFF_FFFF, 32'h0000_001E};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0002, 32'hFFFF_FFE3, 32'hFFFF_FFFE, 32'h0000_001D};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0002, 32'hFFFF_FFE3, 32'hFFFF_FFFE, 32'h0000_001D};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0003, 32'hFFFF_FFE3, 32'hFFFF_FFFD, 32'h0000_001D};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFE4, 32'hFFFF_FFFC, 32'h0000_001C};

        rst_n     = 1'b0;
        count_sw  = 1'b0;
        thresh_sw = 1'b0;
        #1;
        check("reset", act_all(), {RST_UP, RST_DN});

        @(negedge count);
        rst_n = 1'b1;
        #1;
        check("release_idle", act_all(), {RST_UP, RST_DN});

        for (int i = 0; i < 6; i++) begin
            count_sw  = vecs[i].cs;
            thresh_sw = vecs[i].ts;
            @(posedge count);
            #1;
            check($sformatf("vec%0d", i), act_all(),
                  exp_all(vecs[i].c, vecs[i].t, vecs[i].cd, vecs[i].td));
        end

        // Thresholds free-run toward the held counters; equality after 32 edges.
        c_m  = 32'h0000_0004;
        t_m  = 32'hFFFF_FFE4;
        cd_m = 32'hFFFF_FFFC;
        td_m = 32'h0000_001C;
        count_sw  = 1'b0;
        thresh_sw = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            t_m  = t_m + 32'd1;
            td_m = td_m - 32'd1;
            @(posedge count);
            #1;
            check($sformatf("hold%0d", k), act_all(), exp_all(c_m, t_m, cd_m, td_m));
            if (k == 32)
                check("hold_equal", {12'b0, gtu, ltu, geu, leu, gts, lts, ges, les},
                      {12'b0, 8'b0011_0011});
            if (k == 33)
                check("hold_pass", {18'b0, ltu, lts}, {18'b0, 2'b11});
        end

        // Signed boundary: 0x80000000 is the signed minimum.
        @(negedge count);
        force dut.counter   = 32'h8000_0000;
        force dut.threshold = 32'h7FFF_FFFF;
        #1;
        check("signed_edge", {15'b0, gtu, ltu, gts, lts, zero}, {15'b0, 5'b10010});
        release dut.counter;
        release dut.threshold;

        // Wrap of the up counter through 0xFFFFFFFF.
        count_sw  = 1'b1;
        thresh_sw = 1'b0;
        force dut.counter = 32'hFFFF_FFFE;
        #1;
        release dut.counter;
        #1;
        check("pre_max", {18'b0, zero, max}, {18'b0, 2'b00});
        @(posedge count);
        #1;
        check("at_max", {18'b0, zero, max}, {18'b0, 2'b01});
        @(posedge count);
        #1;
        check("wrap_zero", {18'b0, zero, max}, {18'b0, 2'b10});

        // Reset asserted between edges clears everything at once.
        thresh_sw = 1'b1;
        repeat (3) @(posedge count);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", act_all(), {RST_UP, RST_DN});
        @(negedge count);
        rst_n = 1'b1;
        #1;
        check("mid_reset_release", act_all(), {RST_UP, RST_DN});
        @(posedge count);
        #1;
        check("after_reset_edge", act_all(),
              exp_all(32'h0000_0001, 32'hFFFF_FFE1, 32'hFFFF_FFFF, 32'h0000_001F));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
